// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: FSM state encoding
// and the default parameter constants used by the top and the bank.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int          DEF_WIDTH      = 32;
  localparam int          DEF_DEPTH      = 32;
  localparam int          DEF_NUM_RD     = 2;
  localparam logic [31:0] DEF_INIT_VALUE = 32'hDEADCAA2;

endpackage

// File: rtl/regfile_bank.sv
// One DEPTH x WIDTH storage bank with a single write port and a single
// combinational read port. The top keeps one copy per read port, all
// written identically, so every read port sees the same contents.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; the clear sequence in the top initialises it
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/regfile_multiport.sv
// Multiport register file with a hardware clear sequence.
// After reset the FSM walks registers 1..DEPTH-1 writing INIT_VALUE, then
// enters RUN and raises ready. Register 0 always reads as zero, reads are
// combinational and same-cycle writes are forwarded to matching read ports.
// Optional feature: define REGFILE_SCOREBOARD_EN to add a per-register
// pending bit scoreboard (ports set_pend, set_addr, pending).
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               DEPTH      = DEF_DEPTH,
  parameter int               NUM_RD     = DEF_NUM_RD,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(DEF_INIT_VALUE),
  localparam int              AW         = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wren,
  input  logic [AW-1:0]           wraddress,
  input  logic [WIDTH-1:0]        data,
  input  logic [NUM_RD*AW-1:0]    rdaddress,
  output logic [NUM_RD*WIDTH-1:0] q,
  output logic                    ready
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                    set_pend,
  input  logic [AW-1:0]           set_addr,
  output logic [NUM_RD-1:0]       pending
`endif
);

  state_t           r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic             r_ready;

  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rdata [NUM_RD];

  // Clear/run sequencer: walks clr_cnt through 1..DEPTH-1, then switches to RUN and raises ready
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_cnt <= AW'(1);
      r_ready   <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + AW'(1);
      if (r_clr_cnt == AW'(DEPTH - 1)) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end
    end
  end

  assign ready = r_ready;

  // The shared bank write port is owned by the clear sequence until RUN; writes to register 0 are discarded
  assign w_we    = (r_state == CLEAR) || (wren && (wraddress != '0));
  assign w_waddr = (r_state == CLEAR) ? r_clr_cnt  : wraddress;
  assign w_wdata = (r_state == CLEAR) ? INIT_VALUE : data;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_bank
    regfile_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clock   (clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (rdaddress[p*AW +: AW]),
      .o_rdata (w_rdata[p])
    );
  end

  // Read mux per port: zero during CLEAR or for register 0, else forwarded write data or bank contents
  always_comb begin
    q = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((r_state == RUN) && (rdaddress[p*AW +: AW] != '0)) begin
        if (wren && (wraddress == rdaddress[p*AW +: AW])) begin
          q[p*WIDTH +: WIDTH] = data;
        end else begin
          q[p*WIDTH +: WIDTH] = w_rdata[p];
        end
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_pend;

  // Pending bits: a RUN write clears its target, set_pend sets its target, and the set is applied last so it wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      if ((r_state == RUN) && wren) begin
        r_pend[wraddress] <= 1'b0;
      end
      if (set_pend && (set_addr != '0)) begin
        r_pend[set_addr] <= 1'b1;
      end
    end
  end

  // Pending lookup per port: register 0 never pending, and a same-cycle RUN write to the address reads as cleared
  always_comb begin
    pending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rdaddress[p*AW +: AW] != '0) begin
        pending[p] = r_pend[rdaddress[p*AW +: AW]] &
                     ~((r_state == RUN) && wren && (wraddress == rdaddress[p*AW +: AW]));
      end
    end
  end
`endif

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, >=4); AW = log2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter INIT_VALUE, default 32'hDEADCAA2, value loaded into registers 1..DEPTH-1 by the clear sequence.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wren  input  1  write enable.
REQ-008 SHALL have port wraddress  input  AW  write register index.
REQ-009 SHALL have port data  input  WIDTH  write data.
REQ-010 SHALL have port rdaddress  input  NUM_RD x AW  read index per port.
REQ-011 SHALL have port q  output  NUM_RD x WIDTH  read data per port.
REQ-012 SHALL have port ready  output  1  high once the clear sequence has completed.
REQ-013 SHALL, with REGFILE_SCOREBOARD_EN defined, add ports set_pend (input, 1), set_addr (input, AW) and pending (output, NUM_RD x 1).

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 SHALL, in CLEAR, write INIT_VALUE to register clr_cnt, then increment clr_cnt (AW bits) each cycle, starting at 1.
REQ-016 SHALL leave CLEAR for RUN on the cycle that writes register DEPTH-1; ready rises on the next clock edge, DEPTH-1 cycles after reset release.
REQ-017 SHALL ignore wren while in CLEAR.
REQ-018 SHALL drive every q to 0 while in CLEAR.
REQ-019 SHALL, in RUN, write data to register wraddress at the clock edge when wren=1 and wraddress!=0.
REQ-020 SHALL make each q port combinational: q[p] = contents of register rdaddress[p].
REQ-021 SHALL return 0 on q[p] whenever rdaddress[p]=0, regardless of any write to register 0.
REQ-022 SHALL forward same-cycle write data: if wren=1, wraddress=rdaddress[p]!=0 and state is RUN, then q[p]=data in that cycle.
REQ-023 SHALL let all NUM_RD ports read the same or different addresses simultaneously with no conflict or stall.

Reset
REQ-024 SHALL, on reset assertion, immediately force state=CLEAR, clr_cnt=1, ready=0 and (if enabled) all pending bits to 0.
REQ-025 SHALL restart the clear sequence from register 1 when reset is asserted mid-clear or during RUN.
REQ-026 SHALL NOT reset storage contents asynchronously; only the clear sequence initialises them.

Configuration
REQ-027 SHALL, with macro REGFILE_SCOREBOARD_EN defined, keep one pending bit per register: set_pend=1 sets bit set_addr; a RUN-state write (wren=1) clears bit wraddress; when both target the same register in the same cycle, set wins.
REQ-028 SHALL, with REGFILE_SCOREBOARD_EN defined, drive pending[p] = bit rdaddress[p] after the same-cycle clear rule (a same-cycle write to that address reads as not pending); register 0 is never pending.
REQ-029 SHALL, without REGFILE_SCOREBOARD_EN, omit set_pend, set_addr, pending and all scoreboard state.

Structure
REQ-030 SHALL place the FSM state enum (CLEAR, RUN) and default parameter constants in shared package regfile_pkg.
REQ-031 SHALL use one sub-module, regfile_bank (one write port, one combinational read port, DEPTH x WIDTH), instantiated NUM_RD times, all sharing the same write port.

Verification
REQ-032 SHALL cover: release reset with DEPTH=32 -> ready rises after 31 cycles; reading reg 5 returns 32'hDEADCAA2, reading reg 0 returns 0.
REQ-033 SHALL cover: in RUN, write 32'h12345678 to reg 7 with rdaddress[0]=7 in the same cycle -> q[0]=32'h12345678 in that cycle and the next.
REQ-034 SHALL cover: write 32'hFFFFFFFF to reg 0 -> q on every port with rdaddress=0 stays 0.
REQ-035 SHALL cover: wren=1 during CLEAR at cycle 3 -> write is dropped and reg shows INIT_VALUE after ready.
REQ-036 SHALL cover: assert reset at cycle 10 of CLEAR -> ready stays 0, then rises 31 cycles after the second release.
REQ-037 SHALL cover (REGFILE_SCOREBOARD_EN): set_pend on reg 9 -> pending=1 when read; wren to reg 9 -> pending=0 in that cycle; set and write to reg 9 together -> pending=1.
